// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader - mode-0 SPI slave, oversampled in clk, that turns a 2-byte start
// address plus data bytes into auto-incrementing single-cycle pixel memory writes.
module spi_pixel_loader #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int PIXELS        = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic [ADDRESS_WIDTH-1:0] address_out,
  output logic [7:0]               data_out,
  output logic                     write_strobe_out,
  output logic                     frame_done,
  output logic                     addr_error
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, DISCARD} state_t;

  localparam logic [15:0]              PIXEL_LIMIT = 16'(PIXELS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_PIXEL  = ADDRESS_WIDTH'(PIXELS - 1);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;
  logic [1:0] sync_valid;

  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       byte_ready;
  logic [7:0] byte_data;

  state_t                   state;
  logic                     armed;
  logic                     wrote_flag;
  logic [7:0]               addr_hi;
  logic [ADDRESS_WIDTH-1:0] ptr;

  logic        sclk_rise;
  logic        cs_active;
  logic [7:0]  next_shift;
  logic [15:0] start_addr;

  assign sclk_rise  = sclk_s2 & ~sclk_s3;
  assign cs_active  = ~cs_s2;
  assign next_shift = {shift[6:0], mosi_s2};
  assign start_addr = {addr_hi, byte_data};

  // sync_valid marks when cs_s2 holds a real sample rather than its reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1    <= 1'b0;
      sclk_s2    <= 1'b0;
      sclk_s3    <= 1'b0;
      cs_s1      <= 1'b1;
      cs_s2      <= 1'b1;
      mosi_s1    <= 1'b0;
      mosi_s2    <= 1'b0;
      sync_valid <= 2'b00;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      byte_ready <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      sclk_s1    <= spi_sclk;
      sclk_s2    <= sclk_s1;
      sclk_s3    <= sclk_s2;
      cs_s1      <= spi_cs_n;
      cs_s2      <= cs_s1;
      mosi_s1    <= spi_mosi;
      mosi_s2    <= mosi_s1;
      sync_valid <= {sync_valid[0], 1'b1};
      byte_ready <= 1'b0;
      if (!cs_active) begin
        bit_cnt <= 3'd0;
        shift   <= 8'd0;
      end else if (sclk_rise) begin
        shift   <= next_shift;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_ready <= 1'b1;
          byte_data  <= next_shift;
        end
      end
    end
  end

  // armed requires CS to be seen inactive before a transaction may start, so a
  // reset in the middle of a transaction cannot resume it
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      armed            <= 1'b0;
      wrote_flag       <= 1'b0;
      addr_hi          <= 8'd0;
      ptr              <= '0;
      address_out      <= '0;
      data_out         <= 8'd0;
      write_strobe_out <= 1'b0;
      frame_done       <= 1'b0;
      addr_error       <= 1'b0;
    end else begin
      write_strobe_out <= 1'b0;
      frame_done       <= 1'b0;
      addr_error       <= 1'b0;
      if (!cs_active) begin
        if (sync_valid[1]) armed <= 1'b1;
        if (state == DATA && wrote_flag) frame_done <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              armed      <= 1'b0;
              wrote_flag <= 1'b0;
              state      <= ADDR_HI;
            end
          end
          ADDR_HI: begin
            if (byte_ready) begin
              addr_hi <= byte_data;
              state   <= ADDR_LO;
            end
          end
          ADDR_LO: begin
            if (byte_ready) begin
              if (start_addr < PIXEL_LIMIT) begin
                ptr   <= ADDRESS_WIDTH'(start_addr);
                state <= DATA;
              end else begin
                addr_error <= 1'b1;
                state      <= DISCARD;
              end
            end
          end
          DATA: begin
            if (byte_ready) begin
              address_out      <= ptr;
              data_out         <= byte_data;
              write_strobe_out <= 1'b1;
              wrote_flag       <= 1'b1;
              ptr              <= (ptr == LAST_PIXEL) ? '0 : ptr + 1'b1;
            end
          end
          DISCARD: state <= DISCARD;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pixel_loader.sv
// tb_spi_pixel_loader - drives SPI transactions and scoreboards the pixel writes,
// frame_done and addr_error pulses of spi_pixel_loader.
module tb_spi_pixel_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [8:0] address_out;
  logic [7:0] data_out;
  logic       write_strobe_out;
  logic       frame_done;
  logic       addr_error;

  spi_pixel_loader #(.ADDRESS_WIDTH(9), .PIXELS(128)) dut (
    .clk              (clk),
    .rst              (rst),
    .spi_sclk         (spi_sclk),
    .spi_cs_n         (spi_cs_n),
    .spi_mosi         (spi_mosi),
    .address_out      (address_out),
    .data_out         (data_out),
    .write_strobe_out (write_strobe_out),
    .frame_done       (frame_done),
    .addr_error       (addr_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int frames = 0;
  int aerrs = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_strobe_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {15'd0, address_out, data_out}, 32'hffffffff);
      end else begin
        exp_val = exp_q.pop_front();
        check("write", {15'd0, address_out, data_out}, {15'd0, exp_val});
        check("strobe_latency", cyc - rise_cyc, 4);
      end
    end
    if (frame_done) frames++;
    if (addr_error) aerrs++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    tick(3);
    spi_sclk = 1'b1;
    rise_cyc = cyc;
    tick(3);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    tick(3);
  endtask

  task automatic cs_end();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic push(input logic [8:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic begin_test();
    frames = 0;
    aerrs  = 0;
  endtask

  task automatic end_test(input string tag, input int exp_frames, input int exp_aerrs);
    check({tag, "_frame_done"}, frames, exp_frames);
    check({tag, "_addr_error"}, aerrs, exp_aerrs);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    tick(4);
    check("reset_address", {23'd0, address_out}, 0);
    check("reset_data", {24'd0, data_out}, 0);
    check("reset_strobe", {31'd0, write_strobe_out}, 0);
    check("reset_frame_done", {31'd0, frame_done}, 0);
    check("reset_addr_error", {31'd0, addr_error}, 0);
    rst = 1'b0;
    tick(4);

    begin_test();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h05);
    push(9'd5, 8'hAA);
    spi_byte(8'hAA);
    push(9'd6, 8'h55);
    spi_byte(8'h55);
    cs_end();
    end_test("basic", 1, 0);
    check("hold_address", {23'd0, address_out}, 6);
    check("hold_data", {24'd0, data_out}, 8'h55);

    begin_test();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h7E);
    push(9'd126, 8'h01);
    spi_byte(8'h01);
    push(9'd127, 8'h02);
    spi_byte(8'h02);
    push(9'd0, 8'h03);
    spi_byte(8'h03);
    cs_end();
    end_test("wrap", 1, 0);

    begin_test();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h80);
    for (int i = 0; i < 3; i++) spi_byte(8'($urandom_range(0, 255)));
    cs_end();
    end_test("bad_address", 0, 1);

    begin_test();
    cs_start();
    spi_byte(8'h80);
    spi_byte(8'h05);
    spi_byte(8'h3C);
    cs_end();
    end_test("high_bits_address", 0, 1);

    begin_test();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h10);
    push(9'd16, 8'h11);
    spi_byte(8'h11);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_end();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h00);
    push(9'd0, 8'h22);
    spi_byte(8'h22);
    cs_end();
    end_test("aborted_byte", 2, 0);

    begin_test();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h20);
    cs_end();
    end_test("header_only", 0, 0);

    begin_test();
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h20);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    spi_byte(8'h99);
    spi_byte(8'h42);
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
    cs_start();
    spi_byte(8'h00);
    spi_byte(8'h03);
    push(9'd3, 8'h77);
    spi_byte(8'h77);
    cs_end();
    end_test("reset_mid_data", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
